// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int unsigned WORD      = 32;
  localparam int unsigned IMM_W     = 16;
  localparam int unsigned JTARGET_W = 26;

  localparam logic [WORD-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_VALID
  } state_t;

  // Sign-extend a 16-bit word offset and convert it to a byte offset.
  function automatic logic [WORD-1:0] sext_sl2(input logic [IMM_W-1:0] imm);
    return {{(WORD-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection: sequential, branch, J-type jump or register jump.
module next_pc_calc
  import fetch_unit_pkg::*;
(
  input  logic [WORD-1:0]      pc,
  input  logic                 branch_taken,
  input  logic [IMM_W-1:0]     branch_imm,
  input  logic                 jump,
  input  logic [JTARGET_W-1:0] jump_target,
  input  logic                 jr,
  input  logic [WORD-1:0]      jr_addr,
  output logic [WORD-1:0]      pc_plus4,
  output logic [WORD-1:0]      next_pc,
  output logic                 misalign
);

  logic [WORD-1:0] branch_target;
  logic [WORD-1:0] jump_addr;

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + sext_sl2(branch_imm);
  assign jump_addr     = {pc_plus4[WORD-1:WORD-4], jump_target, 2'b00};

  // Priority select: jr > jump > branch > sequential.
  always_comb begin
    next_pc  = pc_plus4;
    misalign = 1'b0;
    if (jr) begin
      next_pc  = {jr_addr[WORD-1:2], 2'b00};
      misalign = (jr_addr[1:0] != 2'b00);
    end else if (jump) begin
      next_pc = jump_addr;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, request/ready reader FSM and
// single-entry instruction holding register presented to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        addr_err
);

  state_t          state;
  state_t          state_nxt;
  logic [WORD-1:0] pc_q;
  logic [WORD-1:0] instr_q;
  logic            addr_err_q;
  logic [WORD-1:0] next_pc;
  logic            misalign;
  logic            consume;
  logic            accept;

  assign accept  = (state == ST_REQ) && imem_ready;
  assign consume = (state == ST_VALID) && !stall;

  next_pc_calc u_next_pc (
    .pc           (pc_q),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .misalign     (misalign)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_REQ;
      ST_REQ:   if (imem_ready) state_nxt = ST_VALID;
      ST_VALID: if (!stall)     state_nxt = ST_REQ;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    imem_req    = (state == ST_REQ);
    instr_valid = (state == ST_VALID);
  end

  // PC, instruction holding register and misalign pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= 1'b0;
      if (accept) instr_q <= imem_rdata;
      if (consume) begin
        pc_q       <= next_pc;
        addr_err_q <= misalign;
      end
    end
  end

  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign instr     = instr_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus a hand-written
// misaligned-jr / wait-state sequence.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic        addr_err;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .addr_err     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;
    logic        br;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] jt;
    logic        jr;
    logic [31:0] jra;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_err;
  } vec_t;

  localparam int unsigned NVEC = 34;
  vec_t tbl [NVEC];

  int vectors     = 0;
  int checks      = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n        = v.rst_n;
    imem_ready   = v.rdy;
    imem_rdata   = v.rdata;
    stall        = v.stall;
    branch_taken = v.br;
    branch_imm   = v.imm;
    jump         = v.jmp;
    jump_target  = v.jt;
    jr           = v.jr;
    jr_addr      = v.jra;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    //          rst  rdy  rdata          stl  br   imm       jmp  jt            jr   jra              req  addr           val  instr          pc             err
    tbl[0]  = '{1'b0,1'b0,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000,1'b0};
    tbl[1]  = '{1'b0,1'b1,32'hDEAD_0001,1'b0,1'b1,16'h0010,1'b1,26'h000_0005,1'b1,32'h0000_0080, 1'b0,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000,1'b0};
    tbl[2]  = '{1'b1,1'b0,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000,1'b0};
    tbl[3]  = '{1'b1,1'b1,32'h2401_0001,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0000,1'b1,32'h2401_0001,32'h0000_0000,1'b0};
    tbl[4]  = '{1'b1,1'b1,32'h0BAD_0BAD,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_0004,1'b0,32'h2401_0001,32'h0000_0004,1'b0};
    tbl[5]  = '{1'b1,1'b1,32'h2402_0002,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0004,1'b1,32'h2402_0002,32'h0000_0004,1'b0};
    tbl[6]  = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_0008,1'b0,32'h2402_0002,32'h0000_0008,1'b0};
    tbl[7]  = '{1'b1,1'b0,32'hDEAD_BEEF,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_0008,1'b0,32'h2402_0002,32'h0000_0008,1'b0};
    tbl[8]  = '{1'b1,1'b0,32'hDEAD_BEEF,1'b0,1'b1,16'h0100,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_0008,1'b0,32'h2402_0002,32'h0000_0008,1'b0};
    tbl[9]  = '{1'b1,1'b0,32'hDEAD_BEEF,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b1,32'h0000_0400, 1'b1,32'h0000_0008,1'b0,32'h2402_0002,32'h0000_0008,1'b0};
    tbl[10] = '{1'b1,1'b1,32'h2403_0003,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0008,1'b1,32'h2403_0003,32'h0000_0008,1'b0};
    tbl[11] = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b1,32'h0000_0100, 1'b1,32'h0000_0100,1'b0,32'h2403_0003,32'h0000_0100,1'b0};
    tbl[12] = '{1'b1,1'b1,32'h8C04_0000,1'b0,1'b1,16'h0040,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0100,1'b1,32'h8C04_0000,32'h0000_0100,1'b0};
    tbl[13] = '{1'b1,1'b1,32'h1111_1111,1'b1,1'b1,16'h0004,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0100,1'b1,32'h8C04_0000,32'h0000_0100,1'b0};
    tbl[14] = '{1'b1,1'b1,32'h2222_2222,1'b1,1'b0,16'h0000,1'b1,26'h3FF_FFFF,1'b0,32'h0000_0000, 1'b0,32'h0000_0100,1'b1,32'h8C04_0000,32'h0000_0100,1'b0};
    tbl[15] = '{1'b1,1'b0,32'h3333_3333,1'b1,1'b0,16'h0000,1'b0,26'h000_0000,1'b1,32'h0000_0003, 1'b0,32'h0000_0100,1'b1,32'h8C04_0000,32'h0000_0100,1'b0};
    tbl[16] = '{1'b1,1'b1,32'h4444_4444,1'b1,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0100,1'b1,32'h8C04_0000,32'h0000_0100,1'b0};
    tbl[17] = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b1,16'hFFFE,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_00FC,1'b0,32'h8C04_0000,32'h0000_00FC,1'b0};
    tbl[18] = '{1'b1,1'b1,32'h1000_0003,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_00FC,1'b1,32'h1000_0003,32'h0000_00FC,1'b0};
    tbl[19] = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b1,32'h1000_0040, 1'b1,32'h1000_0040,1'b0,32'h1000_0003,32'h1000_0040,1'b0};
    tbl[20] = '{1'b1,1'b1,32'h0800_0010,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h1000_0040,1'b1,32'h0800_0010,32'h1000_0040,1'b0};
    tbl[21] = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b1,16'h0100,1'b1,26'h000_0010,1'b0,32'h0000_0000, 1'b1,32'h1000_0040,1'b0,32'h0800_0010,32'h1000_0040,1'b0};
    tbl[22] = '{1'b1,1'b1,32'h03E0_0008,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h1000_0040,1'b1,32'h03E0_0008,32'h1000_0040,1'b0};
    tbl[23] = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b1,16'h0020,1'b1,26'h3FF_FFFF,1'b1,32'h0000_2003, 1'b1,32'h0000_2000,1'b0,32'h03E0_0008,32'h0000_2000,1'b1};
    tbl[24] = '{1'b1,1'b0,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_2000,1'b0,32'h03E0_0008,32'h0000_2000,1'b0};
    tbl[25] = '{1'b1,1'b1,32'hAC05_0004,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_2000,1'b1,32'hAC05_0004,32'h0000_2000,1'b0};
    tbl[26] = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b1,32'hFFFF_FFFC, 1'b1,32'hFFFF_FFFC,1'b0,32'hAC05_0004,32'hFFFF_FFFC,1'b0};
    tbl[27] = '{1'b1,1'b1,32'h00A6_3020,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'hFFFF_FFFC,1'b1,32'h00A6_3020,32'hFFFF_FFFC,1'b0};
    tbl[28] = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_0000,1'b0,32'h00A6_3020,32'h0000_0000,1'b0};
    tbl[29] = '{1'b1,1'b1,32'h0000_0020,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0000,1'b1,32'h0000_0020,32'h0000_0000,1'b0};
    tbl[30] = '{1'b1,1'b1,32'h0000_0000,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b1,32'h0000_0040, 1'b1,32'h0000_0040,1'b0,32'h0000_0020,32'h0000_0040,1'b0};
    tbl[31] = '{1'b0,1'b1,32'hAAAA_AAAA,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000,1'b0};
    tbl[32] = '{1'b1,1'b1,32'hBBBB_BBBB,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b1,32'h0000_0000,1'b0,32'h0000_0000,32'h0000_0000,1'b0};
    tbl[33] = '{1'b1,1'b1,32'h3C01_ABCD,1'b0,1'b0,16'h0000,1'b0,26'h000_0000,1'b0,32'h0000_0000, 1'b0,32'h0000_0000,1'b1,32'h3C01_ABCD,32'h0000_0000,1'b0};

    drive(tbl[0]);
    for (int unsigned i = 0; i < NVEC; i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      vectors++;
      chk("imem_req",    i, {31'd0, imem_req},    {31'd0, tbl[i].e_req});
      chk("imem_addr",   i, imem_addr,            tbl[i].e_addr);
      chk("instr_valid", i, {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
      chk("instr",       i, instr,                tbl[i].e_instr);
      chk("pc_out",      i, pc_out,               tbl[i].e_pc);
      chk("pc_plus4",    i, pc_plus4,             tbl[i].e_pc + 32'd4);
      chk("addr_err",    i, {31'd0, addr_err},    {31'd0, tbl[i].e_err});
    end

    // Misaligned jr (low bits 01) alongside a branch, then five wait states.
    jr = 1'b1; jr_addr = 32'h0000_0101; branch_taken = 1'b1; branch_imm = 16'h0010;
    imem_ready = 1'b0; stall = 1'b0;
    @(posedge clk); #1; vectors++;
    chk("seq_jr_addr", 100, imem_addr, 32'h0000_0100);
    chk("seq_jr_err",  100, {31'd0, addr_err}, 32'd1);
    chk("seq_jr_req",  100, {31'd0, imem_req}, 32'd1);
    jr = 1'b0; branch_taken = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; vectors++;
      chk("seq_wait_req",   101 + k, {31'd0, imem_req}, 32'd1);
      chk("seq_wait_addr",  101 + k, imem_addr, 32'h0000_0100);
      chk("seq_wait_valid", 101 + k, {31'd0, instr_valid}, 32'd0);
      chk("seq_wait_err",   101 + k, {31'd0, addr_err}, 32'd0);
    end
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++; vectors++;
    end while (!instr_valid && cyc < 4);
    chk("seq_latency", 110, cyc, 32'd1);
    chk("seq_instr",   110, instr, 32'h1234_5678);
    chk("seq_pc",      110, pc_out, 32'h0000_0100);
    chk("seq_pc4",     110, pc_plus4, 32'h0000_0104);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
